// File: rtl/riscv_pkg.sv
// Shared types and decode helpers for the RV32I load/store unit.
// The LSU_MISALIGN_TRAP_EN macro is consumed by riscv_lsu, not by this package.
package riscv_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } lsu_state_t;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } lsu_size_t;

  // Reserved funct3 codes fall through to a word access.
  function automatic lsu_size_t f3_size(input logic [2:0] f3);
    lsu_size_t sz;
    case (f3)
      F3_B, F3_BU: sz = SZ_B;
      F3_H, F3_HU: sz = SZ_H;
      default:     sz = SZ_W;
    endcase
    return sz;
  endfunction

  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a);
    logic mis;
    case (f3_size(f3))
      SZ_B:    mis = 1'b0;
      SZ_H:    mis = a[0];
      default: mis = (a != 2'b00);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane logic: byte enables, store-data replication and
// load-lane extraction with sign/zero extension. Misaligned halves/words are truncated.
module lsu_align
  import riscv_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);

  lsu_size_t   size_s;
  logic [31:0] shifted_s;
  logic [7:0]  lane_b_s;
  logic [15:0] lane_h_s;

  assign size_s    = f3_size(funct3_i);
  assign shifted_s = rdata_i >> {addr_lo_i, 3'b000};
  assign lane_b_s  = shifted_s[7:0];
  assign lane_h_s  = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

  always_comb begin
    be_o    = 4'b0000;
    wdata_o = 32'h0000_0000;
    rdata_o = 32'h0000_0000;
    case (size_s)
      SZ_B: begin
        be_o    = 4'b0001 << addr_lo_i;
        wdata_o = {4{wdata_i[7:0]}};
        // funct3[2] distinguishes the unsigned variants (LBU/LHU).
        rdata_o = funct3_i[2] ? {24'h00_0000, lane_b_s} : {{24{lane_b_s[7]}}, lane_b_s};
      end
      SZ_H: begin
        be_o    = 4'b0011 << {addr_lo_i[1], 1'b0};
        wdata_o = {2{wdata_i[15:0]}};
        rdata_o = funct3_i[2] ? {16'h0000, lane_h_s} : {{16{lane_h_s[15]}}, lane_h_s};
      end
      default: begin
        be_o    = 4'b1111;
        wdata_o = wdata_i;
        rdata_o = rdata_i;
      end
    endcase
  end

endmodule

// File: rtl/riscv_lsu.sv
// RV32I load/store unit: one req/ack bus transaction per request, with timeout.
// Define LSU_MISALIGN_TRAP_EN to answer misaligned half/word accesses with an error instead of truncating.
module riscv_lsu
  import riscv_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned CNT_W          = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic [4:0]  rsp_rd,
  output logic        rsp_err
);

  lsu_state_t  state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [2:0]  f3_q, f3_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [4:0]  rd_q, rd_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic [4:0]  rsp_rd_q, rsp_rd_d;
  logic        rsp_err_q, rsp_err_d;

  logic        in_bus_s;
  logic        timeout_s;
  logic        trap_s;
  logic [3:0]  be_s;
  logic [31:0] st_data_s;
  logic [31:0] ld_data_s;

  lsu_align u_align (
    .funct3_i  (f3_q),
    .addr_lo_i (addr_q[1:0]),
    .wdata_i   (wdata_q),
    .rdata_i   (mem_rdata),
    .be_o      (be_s),
    .wdata_o   (st_data_s),
    .rdata_o   (ld_data_s)
  );

`ifdef LSU_MISALIGN_TRAP_EN
  assign trap_s = is_misaligned(req_funct3, req_addr[1:0]);
`else
  assign trap_s = 1'b0;
`endif

  assign in_bus_s  = (state_q == BUS);
  assign timeout_s = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // Bus outputs decode straight from state so an async reset drops mem_req at once.
  assign req_ready = (state_q == IDLE);
  assign mem_req   = in_bus_s;
  assign mem_we    = in_bus_s ? we_q : 1'b0;
  assign mem_addr  = in_bus_s ? {addr_q[31:2], 2'b00} : 32'h0000_0000;
  assign mem_be    = in_bus_s ? be_s : 4'b0000;
  assign mem_wdata = in_bus_s ? st_data_s : 32'h0000_0000;

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_rd    = rsp_rd_q;
  assign rsp_err   = rsp_err_q;

  // Next-state, request capture and response formation.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    f3_d        = f3_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rd_d        = rd_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_rd_d    = rsp_rd_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          f3_d    = req_funct3;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          rd_d    = req_rd;
          cnt_d   = {CNT_W{1'b0}};
          if (trap_s) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = 32'h0000_0000;
            rsp_rd_d    = req_rd;
          end else begin
            state_d = BUS;
          end
        end else begin
          state_d = IDLE;
        end
      end
      BUS: begin
        cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        // An ack arriving on the last allowed cycle still counts as success.
        if (mem_ack) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = we_q ? 32'h0000_0000 : ld_data_s;
          rsp_rd_d    = rd_q;
        end else if (timeout_s) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = 32'h0000_0000;
          rsp_rd_d    = rd_q;
        end else begin
          state_d = BUS;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, request and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= {CNT_W{1'b0}};
      we_q        <= 1'b0;
      f3_q        <= 3'b000;
      addr_q      <= 32'h0000_0000;
      wdata_q     <= 32'h0000_0000;
      rd_q        <= 5'd0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0000_0000;
      rsp_rd_q    <= 5'd0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      f3_q        <= f3_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rd_q        <= rd_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_rd_q    <= rsp_rd_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

endmodule

// File: tb/tb_riscv_lsu.sv
// Directed, table-driven bench for riscv_lsu plus hand sequences for reset and stray acks.
module tb_riscv_lsu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic [4:0]  req_rd = 5'd0;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic [4:0]  rsp_rd;
  logic        rsp_err;

  always #5 clk = ~clk;

  riscv_lsu #(.TIMEOUT_CYCLES(16), .CNT_W(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_rd(rsp_rd), .rsp_err(rsp_err)
  );

`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  localparam int NV = 13;
  localparam logic [7:0] NOACK = 8'd255;

  typedef struct packed {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  rd;
    logic [7:0]  dly;
    logic [31:0] rdata;
    logic        bus;
    logic [3:0]  be;
    logic [31:0] maddr;
    logic [31:0] mwdata;
    logic [31:0] rsp;
    logic        err;
  } vec_t;

  vec_t vecs [NV];
  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [4:0] rd, input logic [7:0] dly,
                              input logic [31:0] rdata, input logic bus, input logic [3:0] be,
                              input logic [31:0] maddr, input logic [31:0] mwdata,
                              input logic [31:0] rsp, input logic err);
    vec_t v;
    v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.rd = rd; v.dly = dly;
    v.rdata = rdata; v.bus = bus; v.be = be; v.maddr = maddr; v.mwdata = mwdata;
    v.rsp = rsp; v.err = err;
    return v;
  endfunction

  vec_t v;
  int   n;
  int   exp_n;

  initial begin
    //            we    f3      addr          wdata         rd     dly    rdata         bus   be       maddr         mwdata        rsp           err
    vecs[0]  = mk(1'b1, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 5'd1,  8'd2,  32'h1234_5678, 1'b1, 4'b1111, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0);
    vecs[1]  = mk(1'b0, 3'b000, 32'h0000_0103, 32'h0000_0000, 5'd7,  8'd0,  32'h80FF_FF00, 1'b1, 4'b1000, 32'h0000_0100, 32'h0000_0000, 32'hFFFF_FF80, 1'b0);
    vecs[2]  = mk(1'b0, 3'b100, 32'h0000_0103, 32'h0000_0000, 5'd9,  8'd1,  32'h80FF_FF00, 1'b1, 4'b1000, 32'h0000_0100, 32'h0000_0000, 32'h0000_0080, 1'b0);
    vecs[3]  = mk(1'b1, 3'b001, 32'h0000_0202, 32'h0000_ABCD, 5'd2,  8'd1,  32'h1234_5678, 1'b1, 4'b1100, 32'h0000_0200, 32'hABCD_ABCD, 32'h0000_0000, 1'b0);
    vecs[4]  = mk(1'b0, 3'b001, 32'h0000_0202, 32'h0000_0000, 5'd11, 8'd3,  32'h8001_1234, 1'b1, 4'b1100, 32'h0000_0200, 32'h0000_0000, 32'hFFFF_8001, 1'b0);
    vecs[5]  = mk(1'b0, 3'b101, 32'h0000_0200, 32'h0000_0000, 5'd12, 8'd0,  32'h8001_9234, 1'b1, 4'b0011, 32'h0000_0200, 32'h0000_0000, 32'h0000_9234, 1'b0);
    vecs[6]  = mk(1'b1, 3'b000, 32'h0000_0301, 32'h0000_00A5, 5'd3,  8'd0,  32'h1234_5678, 1'b1, 4'b0010, 32'h0000_0300, 32'hA5A5_A5A5, 32'h0000_0000, 1'b0);
    vecs[7]  = mk(1'b0, 3'b000, 32'h0000_0101, 32'h0000_0000, 5'd13, 8'd2,  32'h0000_7F00, 1'b1, 4'b0010, 32'h0000_0100, 32'h0000_0000, 32'h0000_007F, 1'b0);
    vecs[8]  = mk(1'b0, 3'b010, 32'h0000_0400, 32'h0000_0000, 5'd14, NOACK, 32'hFFFF_FFFF, 1'b1, 4'b1111, 32'h0000_0400, 32'h0000_0000, 32'h0000_0000, 1'b1);
    vecs[9]  = TRAP ?
               mk(1'b0, 3'b010, 32'h0000_0101, 32'h0000_0000, 5'd15, 8'd0,  32'hCAFE_F00D, 1'b0, 4'b0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b1) :
               mk(1'b0, 3'b010, 32'h0000_0101, 32'h0000_0000, 5'd15, 8'd0,  32'hCAFE_F00D, 1'b1, 4'b1111, 32'h0000_0100, 32'h0000_0000, 32'hCAFE_F00D, 1'b0);
    vecs[10] = mk(1'b0, 3'b011, 32'h0000_0104, 32'h0000_0000, 5'd16, 8'd1,  32'h1122_3344, 1'b1, 4'b1111, 32'h0000_0104, 32'h0000_0000, 32'h1122_3344, 1'b0);
    vecs[11] = TRAP ?
               mk(1'b0, 3'b001, 32'h0000_0203, 32'h0000_0000, 5'd17, 8'd0,  32'h7FFF_0000, 1'b0, 4'b0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b1) :
               mk(1'b0, 3'b001, 32'h0000_0203, 32'h0000_0000, 5'd17, 8'd0,  32'h7FFF_0000, 1'b1, 4'b1100, 32'h0000_0200, 32'h0000_0000, 32'h0000_7FFF, 1'b0);
    vecs[12] = mk(1'b0, 3'b010, 32'h0000_0500, 32'h0000_0000, 5'd18, 8'd15, 32'h5A5A_5A5A, 1'b1, 4'b1111, 32'h0000_0500, 32'h0000_0000, 32'h5A5A_5A5A, 1'b0);

    // Reset state.
    repeat (2) @(negedge clk);
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);

    for (int i = 0; i < NV; i++) begin
      v = vecs[i];
      @(negedge clk);
      chk($sformatf("v%0d_ready", i), {31'd0, req_ready}, 32'd1);
      req_valid = 1'b1; req_we = v.we; req_funct3 = v.f3;
      req_addr = v.addr; req_wdata = v.wdata; req_rd = v.rd;
      @(negedge clk);
      req_valid = 1'b0;
      chk($sformatf("v%0d_mem_req", i), {31'd0, mem_req}, {31'd0, v.bus});
      if (v.bus) begin
        chk($sformatf("v%0d_mem_addr", i), mem_addr, v.maddr);
        chk($sformatf("v%0d_mem_be", i), {28'd0, mem_be}, {28'd0, v.be});
        chk($sformatf("v%0d_mem_wdata", i), mem_wdata, v.mwdata);
        chk($sformatf("v%0d_mem_we", i), {31'd0, mem_we}, {31'd0, v.we});
      end
      n = 0;
      while (!rsp_valid && n < 40) begin
        mem_ack   = (n == int'(v.dly));
        mem_rdata = (n == int'(v.dly)) ? v.rdata : 32'hBAD0_BAD0;
        @(negedge clk);
        mem_ack = 1'b0;
        n++;
      end
      exp_n = !v.bus ? 0 : ((v.dly == NOACK) ? 16 : int'(v.dly) + 1);
      chk($sformatf("v%0d_latency", i), n, exp_n);
      chk($sformatf("v%0d_rsp_valid", i), {31'd0, rsp_valid}, 32'd1);
      chk($sformatf("v%0d_rsp_rdata", i), rsp_rdata, v.rsp);
      chk($sformatf("v%0d_rsp_rd", i), {27'd0, rsp_rd}, {27'd0, v.rd});
      chk($sformatf("v%0d_rsp_err", i), {31'd0, rsp_err}, {31'd0, v.err});
      chk($sformatf("v%0d_resp_mem_req", i), {31'd0, mem_req}, 32'd0);
      @(negedge clk);
      chk($sformatf("v%0d_pulse_end", i), {31'd0, rsp_valid}, 32'd0);
      chk($sformatf("v%0d_rdata_hold", i), rsp_rdata, v.rsp);
      chk($sformatf("v%0d_ready_after", i), {31'd0, req_ready}, 32'd1);
    end

    // Stray ack while idle must not produce a response.
    mem_ack = 1'b1; mem_rdata = 32'h7777_7777;
    @(negedge clk);
    mem_ack = 1'b0;
    chk("stray_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("stray_ready", {31'd0, req_ready}, 32'd1);
    @(negedge clk);
    chk("stray_rsp_valid2", {31'd0, rsp_valid}, 32'd0);

    // Reset asserted mid-BUS.
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h0000_0600; req_rd = 5'd21;
    @(negedge clk);
    req_valid = 1'b0;
    chk("mid_mem_req_before", {31'd0, mem_req}, 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_mem_req_drop", {31'd0, mem_req}, 32'd0);
    chk("mid_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("post_rst_rsp_valid%0d", k), {31'd0, rsp_valid}, 32'd0);
      chk($sformatf("post_rst_mem_req%0d", k), {31'd0, mem_req}, 32'd0);
    end
    chk("post_rst_ready", {31'd0, req_ready}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
